// File: rtl/disp_mux_amisha_if.sv
// Digit inputs and display outputs of the stop-watch display multiplexer.
interface disp_mux_amisha_if;
   logic [3:0] d2_amisha;
   logic [3:0] d1_amisha;
   logic [3:0] d0_amisha;
   logic       blank_en_amisha;
   logic [3:0] an_amisha;
   logic [7:0] sseg_amisha;

   // Digit source: drives BCD digits and blanking, observes the display.
   modport master (
      output d2_amisha,
      output d1_amisha,
      output d0_amisha,
      output blank_en_amisha,
      input  an_amisha,
      input  sseg_amisha
   );

   // Display multiplexer.
   modport slave (
      input  d2_amisha,
      input  d1_amisha,
      input  d0_amisha,
      input  blank_en_amisha,
      output an_amisha,
      output sseg_amisha
   );
endinterface

// File: rtl/disp_mux_amisha.sv
// Time-multiplexed 4-position seven-segment driver for an "SS.t" stop-watch.
// Digits are shadowed once per frame so a frame never shows mixed input values.
module disp_mux_amisha #(
   parameter int unsigned REFRESH_BITS = 18
) (
   input logic               clk_amisha,
   input logic               reset_amisha,
   disp_mux_amisha_if.slave  bus
);

   logic [REFRESH_BITS-1:0] q_q;
   logic [3:0]              s2_q, s1_q, s0_q;
   logic [3:0]              an_q, an_d;
   logic [7:0]              sseg_q, sseg_d;
   logic [1:0]              idx;
   logic                    frame_end;

   // Active-low segment pattern {dp,g,f,e,d,c,b,a}, dp off; non-BCD shows a dash.
   function automatic logic [7:0] decode(input logic [3:0] v);
      logic [7:0] seg;
      case (v)
         4'd0:    seg = 8'hC0;
         4'd1:    seg = 8'hF9;
         4'd2:    seg = 8'hA4;
         4'd3:    seg = 8'hB0;
         4'd4:    seg = 8'h99;
         4'd5:    seg = 8'h92;
         4'd6:    seg = 8'h82;
         4'd7:    seg = 8'hF8;
         4'd8:    seg = 8'h80;
         4'd9:    seg = 8'h90;
         default: seg = 8'hBF;
      endcase
      return seg;
   endfunction

   assign idx       = q_q[REFRESH_BITS-1 -: 2];
   assign frame_end = &q_q;

   // Select anode and segment pattern for the current slot.
   always_comb begin
      an_d   = 4'b1111;
      sseg_d = 8'hFF;
      unique case (idx)
         2'd0: begin
            an_d   = 4'b1110;
            sseg_d = decode(s0_q);
         end
         2'd1: begin
            an_d   = 4'b1101;
            sseg_d = decode(s1_q) & 8'h7F;  // decimal point between seconds and tenths
         end
         2'd2: begin
            // blank_en is used live, not shadowed
            if (bus.blank_en_amisha && (s2_q == 4'd0)) begin
               an_d   = 4'b1111;
               sseg_d = 8'hFF;
            end else begin
               an_d   = 4'b1011;
               sseg_d = decode(s2_q);
            end
         end
         2'd3: begin
            an_d   = 4'b1111;
            sseg_d = 8'hFF;
         end
      endcase
   end

   // Refresh counter, per-frame digit shadows and registered display outputs.
   always_ff @(posedge clk_amisha) begin
      if (reset_amisha) begin
         q_q    <= '0;
         s2_q   <= 4'd0;
         s1_q   <= 4'd0;
         s0_q   <= 4'd0;
         an_q   <= 4'b1111;
         sseg_q <= 8'hFF;
      end else begin
         q_q <= q_q + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
         if (frame_end) begin
            s2_q <= bus.d2_amisha;
            s1_q <= bus.d1_amisha;
            s0_q <= bus.d0_amisha;
         end
         an_q   <= an_d;
         sseg_q <= sseg_d;
      end
   end

   assign bus.an_amisha   = an_q;
   assign bus.sseg_amisha = sseg_q;

endmodule

// File: tb/tb_disp_mux_amisha.sv
// Scoreboard bench for disp_mux_amisha with a 16-cycle frame (REFRESH_BITS=4).
module tb_disp_mux_amisha;

   typedef struct {
      logic [3:0] an;
      logic [7:0] sseg;
      string      name;
   } exp_t;

   logic clk_amisha;
   logic reset_amisha;
   int   n_checks;
   int   n_pass;
   exp_t sb[$];

   disp_mux_amisha_if bus ();

   disp_mux_amisha #(
      .REFRESH_BITS (4)
   ) dut (
      .clk_amisha   (clk_amisha),
      .reset_amisha (reset_amisha),
      .bus          (bus)
   );

   initial begin
      clk_amisha = 1'b0;
      forever #5 clk_amisha = ~clk_amisha;
   end

   // Monitor: the DUT presents a new output every edge; compare against the queue head.
   always @(posedge clk_amisha) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_checks++;
         if (bus.an_amisha === e.an && bus.sseg_amisha === e.sseg) begin
            n_pass++;
         end else begin
            $display("FAIL %s: got an=%b sseg=%h, expected an=%b sseg=%h",
                     e.name, bus.an_amisha, bus.sseg_amisha, e.an, e.sseg);
         end
         n_checks++;
         if ($countones(~bus.an_amisha) <= 1) begin
            n_pass++;
         end else begin
            $display("FAIL onehot_%s: got an=%b, expected at most one low bit",
                     e.name, bus.an_amisha);
         end
      end
   end

   // Queue the expected output of the coming edge, then advance to the next negedge.
   task automatic expect_edges(input logic [3:0] an, input logic [7:0] sseg,
                               input string name, input int n);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         e.an   = an;
         e.sseg = sseg;
         e.name = name;
         sb.push_back(e);
         @(negedge clk_amisha);
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset_amisha        = 1'b1;
      bus.d2_amisha       = 4'd1;
      bus.d1_amisha       = 4'd2;
      bus.d0_amisha       = 4'd3;
      bus.blank_en_amisha = 1'b0;
      @(negedge clk_amisha);

      expect_edges(4'b1111, 8'hFF, "reset", 3);
      reset_amisha = 1'b0;

      // Frame 1: zero shadows; inputs 1,2,3 captured on its last edge.
      expect_edges(4'b1110, 8'hC0, "f1_s0", 4);
      expect_edges(4'b1101, 8'h40, "f1_s1", 4);
      expect_edges(4'b1011, 8'hC0, "f1_s2", 4);
      expect_edges(4'b1111, 8'hFF, "f1_s3", 4);

      // Frame 2: 1 2. 3; inputs changed at cycle 5 must not show this frame.
      expect_edges(4'b1110, 8'hB0, "f2_s0", 4);
      bus.d0_amisha       = 4'd7;
      bus.d2_amisha       = 4'd0;
      bus.blank_en_amisha = 1'b1;
      expect_edges(4'b1101, 8'h24, "f2_s1", 4);
      expect_edges(4'b1011, 8'hF9, "f2_s2", 4);
      expect_edges(4'b1111, 8'hFF, "f2_s3", 4);

      // Frame 3: new d0=7, d2=0 blanked, then blanking dropped mid-slot (live).
      expect_edges(4'b1110, 8'hF8, "f3_s0_shadow", 4);
      bus.d0_amisha = 4'hA;
      bus.d1_amisha = 4'hF;
      expect_edges(4'b1101, 8'h24, "f3_s1", 4);
      expect_edges(4'b1111, 8'hFF, "f3_s2_blank", 2);
      bus.blank_en_amisha = 1'b0;
      expect_edges(4'b1011, 8'hC0, "f3_s2_noblank", 2);
      expect_edges(4'b1111, 8'hFF, "f3_s3", 4);

      // Frame 4: non-BCD digits show a dash; dp still applied in slot 1.
      expect_edges(4'b1110, 8'hBF, "f4_s0_bad", 4);
      expect_edges(4'b1101, 8'h3F, "f4_s1_bad", 4);
      expect_edges(4'b1011, 8'hC0, "f4_s2", 4);
      expect_edges(4'b1111, 8'hFF, "f4_s3", 4);

      // Frame 5: reset in slot 1, then a fresh frame with cleared shadows.
      expect_edges(4'b1110, 8'hBF, "f5_s0", 4);
      expect_edges(4'b1101, 8'h3F, "f5_s1", 1);
      reset_amisha = 1'b1;
      expect_edges(4'b1111, 8'hFF, "midrst", 1);
      reset_amisha = 1'b0;
      bus.blank_en_amisha = 1'b1;
      expect_edges(4'b1110, 8'hC0, "rel_s0", 4);
      expect_edges(4'b1101, 8'h40, "rel_s1", 4);
      expect_edges(4'b1111, 8'hFF, "rel_s2_blank", 4);

      // Bounded drain of the scoreboard.
      for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk_amisha);
      if (sb.size() > 0) begin
         n_checks++;
         $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/disp_mux_amisha.md
DISP_MUX_AMISHA -- requirements
Module: disp_mux_amisha

Interface
REQ-001 SHALL have parameter REFRESH_BITS, default 18, giving the refresh counter width; each digit slot lasts 2^(REFRESH_BITS-2) cycles; minimum value 3.
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk_amisha input 1, rising-edge clock.
REQ-003 SHALL have port reset_amisha, input, 1 bit, synchronous, active-high reset.
REQ-004 SHALL have port d2_amisha, input, 4 bits, BCD digit: stop-watch seconds tens.
REQ-005 SHALL have port d1_amisha, input, 4 bits, BCD digit: stop-watch seconds units.
REQ-006 SHALL have port d0_amisha, input, 4 bits, BCD digit: stop-watch tenths.
REQ-007 SHALL have port blank_en_amisha, input, 1 bit, which enables leading-zero blanking of d2.
REQ-008 SHALL have port an_amisha, output, 4 bits, registered, active-low anode enables; bit i selects display position i.
REQ-009 SHALL have port sseg_amisha, output, 8 bits, registered, active-low segments {dp,g,f,e,d,c,b,a}.

Function
REQ-010 SHALL keep a free-running REFRESH_BITS-bit counter q, incrementing every cycle when not in reset and wrapping from all-ones to 0.
REQ-011 SHALL use slot index idx = q[REFRESH_BITS-1:REFRESH_BITS-2], so one frame is 2^REFRESH_BITS cycles covering slots 0,1,2,3.
REQ-012 SHALL hold shadow registers s2/s1/s0, loaded from d2/d1/d0 only on the edge where q (pre-increment) is all-ones; inputs changing mid-frame SHALL NOT alter the current frame.
REQ-013 SHALL load output registers on each non-reset edge from the pre-increment idx and the shadow values, giving one cycle of latency from the counter to the pins.
REQ-014 SHALL drive idx 0 as an=1110 with sseg=decode(s0) and dp off.
REQ-015 SHALL drive idx 1 as an=1101 with sseg=decode(s1) and dp on (bit7=0), forming the "SS.t" format.
REQ-016 SHALL drive idx 2 as an=1011 with sseg=decode(s2) and dp off; when blank_en=1 and s2==0, it SHALL drive an=1111 and sseg=FF instead.
REQ-017 SHALL drive idx 3, an unused position, as an=1111 and sseg=FF.
REQ-018 SHALL decode values 0-9 with dp off as C0,F9,A4,B0,99,92,82,F8,80,90 (hex).
REQ-019 SHALL decode non-BCD values A-F as BF (segment g only, dash), with dp still applied per slot.
REQ-020 SHALL use blank_en as sampled live at the edge and SHALL NOT shadow it.
REQ-021 SHALL assert at most one anode low in any cycle.

Reset
REQ-022 SHALL, on a reset_amisha=1 edge, load q=0, s2=s1=s0=0, an=1111 and sseg=FF, regardless of current state, including mid-frame.
REQ-023 SHALL, on the first edge after reset deasserts, output idx 0 (an=1110, sseg=C0), and SHALL display all-zero shadows for the whole first frame.
REQ-024 SHALL have the new inputs, captured at the end of the first frame, appear from edge 2^REFRESH_BITS+1 after reset release.

Verification (REFRESH_BITS=4: 4 cycles per slot, 16-cycle frame)
REQ-025 SHALL cover reset: hold reset 3 cycles -> an=1111, sseg=FF; edges 1-4 after release give an=1110, sseg=C0; edges 5-8 give an=1101, sseg=40.
REQ-026 SHALL cover normal display: d2=1, d1=2, d0=3, blank_en=0 -> second frame gives an=1110/sseg=B0 x4, then an=1101/sseg=24 x4, then an=1011/sseg=F9 x4, then an=1111/sseg=FF x4.
REQ-027 SHALL cover leading-zero blanking: d2=0, blank_en=1 -> slot 2 gives an=1111, sseg=FF; with blank_en=0 -> an=1011, sseg=C0.
REQ-028 SHALL cover shadowing: change d0 from 3 to 7 at cycle 5 of a frame -> slot 0 stays B0 through that frame and shows F8 from the next frame.
REQ-029 SHALL cover invalid BCD: d0=A, d1=F -> slot 0 gives sseg=BF and slot 1 gives sseg=3F.
REQ-030 SHALL cover reset mid-frame: assert reset during slot 1 -> next edge gives an=1111, sseg=FF; after release, edge 1 gives an=1110, sseg=C0 with the shadows cleared.
